// File: rtl/psum_accumulator_pkg.sv
// Shared types, default widths and the sign-extension helper for the psum accumulator.
package psum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PSUM_BW    = 8;
  localparam int ACC_BW     = 16;
  localparam int SEXT_MAX_W = 64;

  // Sign-extends the low w bits of raw to SEXT_MAX_W; callers truncate to their own width.
  function automatic logic [SEXT_MAX_W-1:0] sext_psum(input logic [SEXT_MAX_W-1:0] raw,
                                                      input int unsigned w);
    logic signed [SEXT_MAX_W-1:0] t;
    int unsigned                  sh;
    sh = SEXT_MAX_W - w;
    t  = signed'(raw << sh);
    return t >>> sh;
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Input (psum) and output (result) valid/ready streams of the psum accumulator.
interface psum_accumulator_if
  import psum_acc_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int acc_bw  = ACC_BW
);
  logic               in_valid;
  logic               in_ready;
  logic [psum_bw-1:0] in_psum;
  logic               out_valid;
  logic               out_ready;
  logic [acc_bw-1:0]  out_data;

  modport master (
    output in_valid, in_psum, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_psum, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/psum_accumulator_acc_relu.sv
// Final add (base + sign-extended psum) and the value loaded into out_data.
// Define PSUM_ACC_RELU_EN to clamp negative results to zero on the output path only.
module acc_relu
  import psum_acc_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int acc_bw  = ACC_BW
) (
  input  logic [acc_bw-1:0]  base,
  input  logic [psum_bw-1:0] psum,
  output logic [acc_bw-1:0]  sum,
  output logic [acc_bw-1:0]  result
);
  logic [acc_bw-1:0] psum_ext;

  assign psum_ext = acc_bw'(sext_psum(SEXT_MAX_W'(psum), psum_bw));
  assign sum      = base + psum_ext;

`ifdef PSUM_ACC_RELU_EN
  assign result = sum[acc_bw-1] ? '0 : sum;
`else
  assign result = sum;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Sums NUM_PASS signed psums into one acc_bw result, presented over a valid/ready stream.
// Optional output ReLU is enabled by defining PSUM_ACC_RELU_EN.
//
// state | meaning
// IDLE  | no group in progress, waiting for the first psum
// ACCUM | 1..NUM_PASS-1 psums of the current group accepted
// HOLD  | completed result on out_data, waiting for out_ready
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int psum_bw  = PSUM_BW,
  parameter int acc_bw   = ACC_BW,
  parameter int NUM_PASS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  psum_accumulator_if.slave   bus,
  output logic                busy
);
  localparam int                CNT_W    = $clog2(NUM_PASS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_PASS);

  state_t            state_q, state_d;
  logic [acc_bw-1:0] acc_q, acc_d;
  logic [acc_bw-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [acc_bw-1:0] base, sum, result;
  logic [CNT_W-1:0]  cnt_base, cnt_inc;
  logic              in_ready, out_valid, in_acc, out_hs, last;

  // A new group always starts from zero; only ACCUM carries the running sum forward.
  assign base     = (state_q == ACCUM) ? acc_q : '0;
  assign cnt_base = (state_q == ACCUM) ? cnt_q : '0;
  assign cnt_inc  = cnt_base + CNT_W'(1);
  assign last     = (cnt_inc == LAST_CNT);
  assign in_acc   = bus.in_valid & in_ready;
  assign out_hs   = out_valid & bus.out_ready;

  acc_relu #(
    .psum_bw (psum_bw),
    .acc_bw  (acc_bw)
  ) u_acc_relu (
    .base   (base),
    .psum   (bus.in_psum),
    .sum    (sum),
    .result (result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  // In HOLD an input accept implies the output handshake, since in_ready follows out_ready.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    if (state_q != HOLD && clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (in_acc) begin
      acc_d = sum;
      cnt_d = cnt_inc;
      if (last) begin
        state_d    = HOLD;
        out_data_d = result;
      end else begin
        state_d = ACCUM;
      end
    end else if (out_hs) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q != IDLE && state_q != ACCUM && state_q != HOLD) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    if (state_q == HOLD) begin
      out_valid = 1'b1;
      in_ready  = bus.out_ready;
    end
    if (clear) in_ready = 1'b0;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: vector table plus multi-cycle corner sequences,
// with a scoreboard queue of expected results popped on each output handshake.
module tb_psum_accumulator;
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic clear   = 1'b0;
  logic busy;

  psum_accumulator_if #(.psum_bw(8), .acc_bw(16)) bus ();

  psum_accumulator #(.psum_bw(8), .acc_bw(16), .NUM_PASS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] p;
    logic [15:0]     raw;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          stalls;
  logic [15:0] exp_q[$];
  int          hs_cyc[$];
  vec_t        vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_of(input logic [15:0] raw);
`ifdef PSUM_ACC_RELU_EN
    return raw[15] ? 16'h0000 : raw;
`else
    return raw;
`endif
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input logic [15:0] r);
    vec_t v;
    v.p[0] = a;
    v.p[1] = b;
    v.p[2] = c;
    v.p[3] = d;
    v.raw  = r;
    return v;
  endfunction

  // Scoreboard: each output handshake pops the oldest expected result.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got 0x%0h expected no output", bus.out_data);
      end else begin
        check("sb_out_data", {16'h0, bus.out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the psum was accepted.
  task automatic send_psum(input logic [7:0] v);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_psum  = v;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected accept");
    end
  endtask

  task automatic send_group(input vec_t v, input bit push);
    if (push) exp_q.push_back(exp_of(v.raw));
    for (int i = 0; i < 4; i++) send_psum(v.p[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    check(name, {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_psum   = '0;
    bus.out_ready = 1'b1;

    vecs[0] = mk(8'd3,    8'hFB,  8'd127, 8'd1,   16'd126);
    vecs[1] = mk(8'h80,   8'h80,  8'h80,  8'h80,  16'hFE00);
    vecs[2] = mk(8'd2,    8'd2,   8'd2,   8'd2,   16'd8);
    vecs[3] = mk(8'd127,  8'd127, 8'd127, 8'd127, 16'd508);
    vecs[4] = mk(8'hFF,   8'hFF,  8'hFF,  8'd2,   16'hFFFF);
    vecs[5] = mk(8'hF9,   8'd3,   8'd0,   8'd0,   16'hFFFC);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_busy",      {31'h0, busy},          32'h0);
    check("rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
    check("rst_out_data",  {16'h0, bus.out_data},  32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: latency, one-cycle pulse, return to idle
    for (int k = 0; k < 6; k++) begin
      send_group(vecs[k], 1'b1);
      check("tbl_out_valid", {31'h0, bus.out_valid}, 32'h1);
      check("tbl_out_data",  {16'h0, bus.out_data},  {16'h0, exp_of(vecs[k].raw)});
      @(posedge clk);
      #1;
      check("tbl_pulse", {31'h0, bus.out_valid}, 32'h0);
      wait_idle("tbl_busy");
    end

    // Backpressure: pending psum waits, then is taken in the output-handshake cycle
    bus.out_ready = 1'b0;
    exp_q.push_back(16'd8);
    for (int i = 0; i < 4; i++) send_psum(8'd2);
    bus.in_psum = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready",  {31'h0, bus.in_ready},  32'h0);
      check("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
      check("bp_out_data",  {16'h0, bus.out_data},  32'd8);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(16'd26);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_on_hs", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    send_psum(8'd6);
    send_psum(8'd7);
    send_psum(8'd8);
    bus.in_valid = 1'b0;
    wait_idle("bp_busy");

    // Back-to-back: 8 ones, two results 4 cycles apart, no stalls
    hs_cyc.delete();
    stalls = 0;
    exp_q.push_back(16'd4);
    exp_q.push_back(16'd4);
    for (int i = 0; i < 8; i++) send_psum(8'd1);
    bus.in_valid = 1'b0;
    wait_idle("b2b_busy");
    check("b2b_stalls",  stalls,          32'd0);
    check("b2b_results", hs_cyc.size(),   32'd2);
    if (hs_cyc.size() == 2) check("b2b_spacing", hs_cyc[1] - hs_cyc[0], 32'd4);

    // Clear mid-group: psum offered under clear is not consumed
    send_psum(8'd10);
    send_psum(8'd20);
    clear        = 1'b1;
    bus.in_psum  = 8'd99;
    @(negedge clk);
    check("clr_in_ready", {31'h0, bus.in_ready}, 32'h0);
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_busy", {31'h0, busy}, 32'h0);
    send_group(mk(8'd1, 8'd1, 8'd1, 8'd1, 16'd4), 1'b1);
    wait_idle("clr_after_busy");

    // Clear in HOLD keeps the result presented
    bus.out_ready = 1'b0;
    send_group(mk(8'd2, 8'd2, 8'd2, 8'd2, 16'd8), 1'b1);
    clear = 1'b1;
    @(negedge clk);
    check("clrh_in_ready", {31'h0, bus.in_ready}, 32'h0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clrh_out_valid", {31'h0, bus.out_valid}, 32'h1);
    check("clrh_out_data",  {16'h0, bus.out_data},  32'd8);
    bus.out_ready = 1'b1;
    wait_idle("clrh_busy");

    // Asynchronous reset mid-group
    send_psum(8'd9);
    send_psum(8'd9);
    bus.in_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("rstm_busy",      {31'h0, busy},          32'h0);
    check("rstm_out_valid", {31'h0, bus.out_valid}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset while a result is held
    bus.out_ready = 1'b0;
    send_group(mk(8'd3, 8'd3, 8'd3, 8'd3, 16'd12), 1'b0);
    check("rsth_pre_valid", {31'h0, bus.out_valid}, 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    check("rsth_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rsth_out_data",  {16'h0, bus.out_data},  32'h0);
    check("rsth_busy",      {31'h0, busy},          32'h0);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_group(mk(8'd1, 8'd1, 8'd1, 8'd1, 16'd4), 1'b1);
    check("rst_after_data", {16'h0, bus.out_data}, 32'd4);
    wait_idle("rst_after_busy");

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
